// File: rtl/bf2i_input_bundler.sv
// Ping-pong bundler: packs a serial I/Q stream into DEPTH-wide bundles for the BF2I stage.
// Optional BUNDLER_BITREV_EN: write sample k of a frame to slot bitrev(k) instead of slot k.
`timescale 1ns/1ps
module bf2i_input_bundler #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic signed [WIDTH-1:0]              s_din_R,
    input  logic signed [WIDTH-1:0]              s_din_Q,
    input  logic                                 s_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic signed [DEPTH-1:0][WIDTH-1:0]   m_dout_R,
    output logic signed [DEPTH-1:0][WIDTH-1:0]   m_dout_Q
);

    localparam int unsigned CW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic             s_ready_d, m_valid_d;

    logic [DEPTH-1:0] mask_q [2];
    logic [WIDTH-1:0] mem_r  [2][DEPTH];
    logic [WIDTH-1:0] mem_q  [2][DEPTH];

    logic             in_acc, out_acc, close;
    logic [CW-1:0]    slot;

    assign in_acc  = s_valid && s_ready;
    assign out_acc = m_valid && m_ready;
    assign close   = in_acc && ((wcnt_q == CW'(DEPTH - 1)) || s_last);

`ifdef BUNDLER_BITREV_EN
    always_comb begin
        slot = '0;
        for (int i = 0; i < int'(CW); i++) begin
            slot[i] = wcnt_q[int'(CW) - 1 - i];
        end
    end
`else
    assign slot = wcnt_q;
`endif

    // State register, including the registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wcnt_q    <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            wcnt_q    <= wcnt_d;
            s_ready   <= s_ready_d;
            m_valid   <= m_valid_d;
        end
    end

    // Next-state: an accepted bank and a closing bank are never the same bank
    always_comb begin
        bank_d = bank_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        if (out_acc) begin
            bank_d[rb_q] = BANK_EMPTY;
            rb_d         = ~rb_q;
        end
        if (in_acc) begin
            if (close) begin
                bank_d[wb_q] = BANK_FULL;
                wcnt_d       = '0;
                wb_d         = ~wb_q;
            end else begin
                bank_d[wb_q] = BANK_FILLING;
                wcnt_d       = wcnt_q + CW'(1);
            end
        end
    end

    // Output decode from next state so the handshake flops track the bank states
    always_comb begin
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
        s_ready_d = (bank_d[wb_d] != BANK_FULL);
        m_valid_d = (bank_d[rb_d] == BANK_FULL);
    end

    // Written-slot masks; the first write into an EMPTY bank starts a fresh mask
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q[0] <= '0;
            mask_q[1] <= '0;
        end else if (in_acc) begin
            if (bank_q[wb_q] == BANK_EMPTY) begin
                mask_q[wb_q] <= DEPTH'(1) << slot;
            end else begin
                mask_q[wb_q] <= mask_q[wb_q] | (DEPTH'(1) << slot);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc) begin
            mem_r[wb_q][slot] <= s_din_R;
            mem_q[wb_q][slot] <= s_din_Q;
        end
    end

    // Unwritten slots read as zero, hiding data left over from earlier frames
    always_comb begin
        m_dout_R = '0;
        m_dout_Q = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (mask_q[rb_q][k]) begin
                m_dout_R[k] = mem_r[rb_q][k];
                m_dout_Q[k] = mem_q[rb_q][k];
            end
        end
    end

endmodule

// File: tb/tb_bf2i_input_bundler.sv
// Directed self-checking bench for bf2i_input_bundler (natural order, or bit-reversed with BUNDLER_BITREV_EN).
`timescale 1ns/1ps
module tb_bf2i_input_bundler;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned DEPTH = 16;

    typedef logic [DEPTH-1:0][WIDTH-1:0] bundle_t;

    logic clk = 1'b0;
    logic rst, s_valid, s_ready, s_last, m_valid, m_ready;
    logic signed [WIDTH-1:0] s_din_R, s_din_Q;
    logic signed [DEPTH-1:0][WIDTH-1:0] m_dout_R, m_dout_Q;

    bundle_t exp_r, exp_q;
    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bf2i_input_bundler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_din_R  (s_din_R),
        .s_din_Q  (s_din_Q),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_dout_R (m_dout_R),
        .m_dout_Q (m_dout_Q)
    );

    function automatic int slot_of(input int k);
        int r;
        r = k;
`ifdef BUNDLER_BITREV_EN
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) r = r | (1 << (3 - i));
        end
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample and waits (bounded) until it is accepted; leaves s_valid high
    task automatic send(input int r, input int q, input logic last);
        logic acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_din_R = WIDTH'(r);
        s_din_Q = WIDTH'(q);
        s_last  = last;
        for (int c = 0; c < 64 && !acc; c++) begin
            acc = s_ready;
            tick();
        end
        if (!acc) begin
            total_cnt++;
            $display("FAIL send_timeout: sample R=%0d not accepted within 64 cycles", r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        s_din_R = '0; s_din_Q = '0;
        tick();
        tick();
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else pass_cnt++;
        total_cnt++; if (m_dout_R !== '0) $display("FAIL reset_dout_R: got %h want 0", m_dout_R); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== '0) $display("FAIL reset_dout_Q: got %h want 0", m_dout_Q); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        exp_r = '0; exp_q = '0;
        for (int k = 0; k < 16; k++) begin
            exp_r[slot_of(k)] = WIDTH'(k);
            exp_q[slot_of(k)] = WIDTH'(-k);
        end
        for (int k = 0; k < 15; k++) send(k, -k, 1'b0);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", m_valid); else pass_cnt++;
        send(15, -15, 1'b0);
        s_valid = 1'b0;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", m_valid); else pass_cnt++;
        total_cnt++; if (m_dout_R !== exp_r) $display("FAIL single_R: got %h want %h", m_dout_R, exp_r); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL single_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        tick();
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_pulse: got %b want 0", m_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic ev;
        int b;
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            total_cnt++; if (s_ready !== 1'b1) $display("FAIL b2b_s_ready[%0d]: got %b want 1", i, s_ready); else pass_cnt++;
            send(i, i + 100, 1'b0);
            ev = (i % 16 == 15);
            total_cnt++; if (m_valid !== ev) $display("FAIL b2b_m_valid[%0d]: got %b want %b", i, m_valid, ev); else pass_cnt++;
            if (ev) begin
                b = i / 16;
                exp_r = '0; exp_q = '0;
                for (int k = 0; k < 16; k++) begin
                    exp_r[slot_of(k)] = WIDTH'(b * 16 + k);
                    exp_q[slot_of(k)] = WIDTH'(b * 16 + k + 100);
                end
                total_cnt++; if (m_dout_R !== exp_r) $display("FAIL b2b_R[%0d]: got %h want %h", b, m_dout_R, exp_r); else pass_cnt++;
                total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL b2b_Q[%0d]: got %h want %h", b, m_dout_Q, exp_q); else pass_cnt++;
            end
        end
        s_valid = 1'b0;
        tick();
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", m_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        logic er;
        n = 0;
        m_ready = 1'b0;
        exp_r = '0; exp_q = '0;
        for (int k = 0; k < 16; k++) begin
            exp_r[slot_of(k)] = WIDTH'(200 + k);
            exp_q[slot_of(k)] = WIDTH'(k);
        end
        for (int c = 0; c < 40; c++) begin
            s_valid = 1'b1;
            s_din_R = (n < 32) ? WIDTH'(200 + n) : WIDTH'(511);
            s_din_Q = WIDTH'(n);
            s_last  = (n >= 32);
            er = (n < 32);
            total_cnt++; if (s_ready !== er) $display("FAIL bp_s_ready[%0d]: got %b want %b", c, s_ready, er); else pass_cnt++;
            if (n >= 16) begin
                total_cnt++; if (m_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, m_valid); else pass_cnt++;
                total_cnt++; if (m_dout_R !== exp_r) $display("FAIL bp_hold_R[%0d]: got %h want %h", c, m_dout_R, exp_r); else pass_cnt++;
            end
            if (s_ready) n++;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++; if (n !== 32) $display("FAIL bp_accepted: got %0d want 32", n); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL bp_bundle0_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_r[slot_of(k)] = WIDTH'(216 + k);
            exp_q[slot_of(k)] = WIDTH'(16 + k);
        end
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", s_ready); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL bp_bundle1_valid: got %b want 1", m_valid); else pass_cnt++;
        total_cnt++; if (m_dout_R !== exp_r) $display("FAIL bp_bundle1_R: got %h want %h", m_dout_R, exp_r); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL bp_bundle1_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", m_valid); else pass_cnt++;
    endtask

    task automatic test_short_frame();
        m_ready = 1'b0;
        exp_r = '0; exp_q = '0;
        for (int k = 0; k < 5; k++) begin
            exp_r[slot_of(k)] = WIDTH'(10 + k);
            exp_q[slot_of(k)] = WIDTH'(50 + k);
        end
        for (int k = 0; k < 4; k++) send(10 + k, 50 + k, 1'b0);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL short_early_valid: got %b want 0", m_valid); else pass_cnt++;
        send(14, 54, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL short_valid: got %b want 1", m_valid); else pass_cnt++;
        total_cnt++; if (m_dout_R !== exp_r) $display("FAIL short_R: got %h want %h", m_dout_R, exp_r); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL short_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL short_no_pad_frame: got %b want 0", m_valid); else pass_cnt++;

        for (int k = 0; k < 16; k++) begin
            exp_r[slot_of(k)] = WIDTH'(300 + k);
            exp_q[slot_of(k)] = WIDTH'(400 + k);
        end
        for (int k = 0; k < 16; k++) send(300 + k, 400 + k, 1'b0);
        s_valid = 1'b0;
        total_cnt++; if (m_dout_R !== exp_r) $display("FAIL full_after_short_R: got %h want %h", m_dout_R, exp_r); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL full_after_short_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;

        exp_r = '0; exp_q = '0;
        exp_r[slot_of(0)] = WIDTH'(7); exp_q[slot_of(0)] = WIDTH'(9);
        exp_r[slot_of(1)] = WIDTH'(8); exp_q[slot_of(1)] = WIDTH'(10);
        send(7, 9, 1'b0);
        send(8, 10, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL short2_valid: got %b want 1", m_valid); else pass_cnt++;
        total_cnt++; if (m_dout_R !== exp_r) $display("FAIL short2_no_stale_R: got %h want %h", m_dout_R, exp_r); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL short2_no_stale_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int k = 0; k < 23; k++) send(k + 1, k + 1, 1'b0);
        s_valid = 1'b0;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", m_valid); else pass_cnt++;
        rst = 1'b1; tick(); rst = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", m_valid); else pass_cnt++;
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", s_ready); else pass_cnt++;
        total_cnt++; if (m_dout_R !== '0) $display("FAIL rstmid_dout: got %h want 0", m_dout_R); else pass_cnt++;
        exp_r = '0; exp_q = '0;
        for (int k = 0; k < 16; k++) begin
            exp_r[slot_of(k)] = WIDTH'(450 + k);
            exp_q[slot_of(k)] = WIDTH'(k + 3);
        end
        for (int k = 0; k < 15; k++) send(450 + k, k + 3, 1'b0);
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rstmid_early_valid: got %b want 0", m_valid); else pass_cnt++;
        send(465, 18, 1'b0);
        s_valid = 1'b0;
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL rstmid_fresh_valid: got %b want 1", m_valid); else pass_cnt++;
        total_cnt++; if (m_dout_R !== exp_r) $display("FAIL rstmid_fresh_R: got %h want %h", m_dout_R, exp_r); else pass_cnt++;
        total_cnt++; if (m_dout_Q !== exp_q) $display("FAIL rstmid_fresh_Q: got %h want %h", m_dout_Q, exp_q); else pass_cnt++;
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++; if (m_valid !== 1'b0) $display("FAIL rstmid_extra_bundle[%0d]: got %b want 0", c, m_valid); else pass_cnt++;
        end
        m_ready = 1'b0;
    endtask

`ifdef BUNDLER_BITREV_EN
    task automatic test_bitrev();
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(k, 0, 1'b0);
        s_valid = 1'b0;
        total_cnt++; if (m_dout_R[8] !== WIDTH'(1)) $display("FAIL bitrev_slot8: got %0d want 1", m_dout_R[8]); else pass_cnt++;
        total_cnt++; if (m_dout_R[4] !== WIDTH'(2)) $display("FAIL bitrev_slot4: got %0d want 2", m_dout_R[4]); else pass_cnt++;
        total_cnt++; if (m_dout_R[12] !== WIDTH'(3)) $display("FAIL bitrev_slot12: got %0d want 3", m_dout_R[12]); else pass_cnt++;
        total_cnt++; if (m_dout_R[15] !== WIDTH'(15)) $display("FAIL bitrev_slot15: got %0d want 15", m_dout_R[15]); else pass_cnt++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_short_frame();
        test_reset_mid();
`ifdef BUNDLER_BITREV_EN
        test_bitrev();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/bf2i_input_bundler.md
# bf2i_input_bundler

Collects a serial stream of complex samples (one I/Q pair per cycle) into 16-wide parallel bundles that feed the first radix-2² butterfly stage (BF2I 4-bundle) of the FFT pipeline. Two bundle banks are used as a ping-pong buffer, so one bank fills while the other is held for the downstream stage; at full input rate a bundle is produced every DEPTH cycles with no bubbles. A short final frame can be closed early with `s_last`; its unwritten slots read as zero.

## Interface
- `WIDTH`, 9: bits per I or Q component, signed two's complement.
- `DEPTH`, 16: samples per bundle; power of two, ≥ 4.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  bundler can accept a sample this cycle.
- `s_din_R`  in  WIDTH signed  input real (I) component.
- `s_din_Q`  in  WIDTH signed  input imaginary (Q) component.
- `s_last`  in  1  with an accepted sample, closes the current frame.
- `m_valid`  out  1  a complete bundle is presented.
- `m_ready`  in  1  downstream takes the bundle (drives BF2I `en`).
- `m_dout_R`  out  [DEPTH-1:0] × WIDTH signed  bundle real parts, index = slot.
- `m_dout_Q`  out  [DEPTH-1:0] × WIDTH signed  bundle imaginary parts.

## Operation
- Input accept: `s_valid && s_ready`. Output accept: `m_valid && m_ready`.
- Each bank has state EMPTY → FILLING → FULL → EMPTY. Write-bank pointer `wb` and read-bank pointer `rb` are 1 bit each, both 0 after reset.
- On input accept: sample is written to slot `wcnt` (natural order) of bank `wb`, and that slot's written bit is set; `wcnt` increments.
- Frame closes on the accept where `wcnt == DEPTH-1` or `s_last == 1`. On close, bank `wb` → FULL, `wcnt` → 0, `wb` toggles.
- `s_last` on slot DEPTH-1 is an ordinary close, with no extra padding frame. `s_last` on slot k < DEPTH-1 closes with slots k+1..DEPTH-1 reading 0.
- A bank entering FILLING has its written mask cleared. Output slot value = stored value if written, else 0. Stale data never appears at the output.
- `s_ready = (bank[wb] != FULL)`. This is registered state only, with no combinational path from `m_ready`.
- `m_valid = (bank[rb] == FULL)`. `m_dout_*` = masked contents of bank `rb`.
- On output accept: bank `rb` → EMPTY and `rb` toggles. Bundles leave in the order they were closed.
- Simultaneous input close into bank X and output accept of bank Y (X≠Y) in one cycle: both take effect.
- Data is stored unmodified. There is no arithmetic and no width growth, because BF2I performs the first growth.

## Timing
- Reset values, visible in the cycle after a `rst`-high edge: `s_ready`=1, `m_valid`=0, `m_dout_R`/`m_dout_Q` all 0. All banks are EMPTY, masks are cleared, and `wcnt`=0.
- `rst` asserted mid-frame or while `m_valid` is high: the partial frame and pending bundles are discarded, and nothing is emitted afterwards.
- Latency: the closing sample is accepted at edge t, and `m_valid` is high from t+1 provided no older bundle is pending.
- `m_valid` and `m_dout_*` are held stable until output accept.
- Throughput: one sample per cycle sustained while `m_ready` is high at least once per DEPTH cycles.
- Back-pressure: with both banks FULL, `s_ready` is 0. An output accept at edge t gives `s_ready`=1 at t+1.
- `s_valid`/`s_din_*`/`s_last` are ignored when `s_ready`=0.

## Configuration
- `BUNDLER_BITREV_EN` defined: sample number k of a frame is written to slot bitrev(k) over log2(DEPTH) bits. For DEPTH=16, k=1 → slot 8 and k=3 → slot 12. Zero-padding of a short frame applies to the slots never written.
- Not defined: natural order, slot = k.
- All handshake and timing rules are identical in both builds.

## Test plan
- Reset, then 16 samples with R=k, Q=-k and `m_ready`=1 → `m_valid` pulses 1 cycle after the 16th accept; `m_dout_R[k]`=k and `m_dout_Q[k]`=-k.
- 64 back-to-back samples with `m_ready`=1 → `s_ready` stays 1, 4 bundles arrive in order with no gaps, and `m_valid` asserts every 16 cycles.
- `m_ready`=0 while 40 samples are offered → `s_ready` drops after the 32nd accept and bundle 0 is held stable. Raising `m_ready` for 1 cycle gives bundle 0, and `s_ready`=1 on the next cycle.
- 5 samples (R=10..14) with `s_last` on the 5th → slots 0..4 = 10..14 and slots 5..15 = 0. The next full frame shows no residue from it.
- `rst` pulsed after 7 samples, then 16 fresh samples → exactly one bundle, containing only the fresh samples.
- With `BUNDLER_BITREV_EN`, R=k for k=0..15 → `m_dout_R[8]`=1, `m_dout_R[4]`=2 and `m_dout_R[15]`=15.
